load_align: RTL and testbench

- Read-side counterpart of the store byte-lane placer. It sits in the MEM/WB path between the synchronous data RAM and the register-file write-back.
- It tracks each load request across the one-cycle RAM read latency and extracts the addressed byte or halfword lane. The result is sign- or zero-extended and delivered as a registered result with a valid flag.
- Misaligned loads are flagged and never issue a RAM read.

---
 rtl/load_align_pkg.sv | 55 +++++
 rtl/load_align_if.sv | 27 ++
 rtl/load_align_extract.sv | 27 ++
 rtl/load_align.sv | 71 +++++++
 tb/tb_load_align.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/load_align_pkg.sv
// Shared load/store lane definitions: load type codes, lane masks,
// the stage-1 request bundle and the lane-select decoder.
package load_align_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LBU = 3'b001,
        LD_LH  = 3'b010,
        LD_LHU = 3'b011,
        LD_LW  = 3'b100
    } ld_type_e;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_B0   = 4'b0001;
    localparam logic [3:0] SEL_B1   = 4'b0010;
    localparam logic [3:0] SEL_B2   = 4'b0100;
    localparam logic [3:0] SEL_B3   = 4'b1000;
    localparam logic [3:0] SEL_H0   = 4'b0011;
    localparam logic [3:0] SEL_H1   = 4'b1100;
    localparam logic [3:0] SEL_W    = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [2:0] ty;
        logic [1:0] off;
        logic       mis;
    } s1_t;

    // An empty mask doubles as the misaligned/illegal indication.
    function automatic logic [3:0] lane_sel(input logic [2:0] ty,
                                            input logic [1:0] off);
        logic [3:0] sel;
        sel = SEL_NONE;
        case (ty)
            LD_LB, LD_LBU: begin
                case (off)
                    2'd0:    sel = SEL_B0;
                    2'd1:    sel = SEL_B1;
                    2'd2:    sel = SEL_B2;
                    default: sel = SEL_B3;
                endcase
            end
            LD_LH, LD_LHU: begin
                if (off == 2'd0)      sel = SEL_H0;
                else if (off == 2'd2) sel = SEL_H1;
            end
            LD_LW: begin
                if (off == 2'd0) sel = SEL_W;
            end
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/load_align_if.sv
// Load request / RAM / write-back bundle between the pipeline
// and the load aligner.
interface load_align_if #(
    parameter int WIDTH = 32
) ();
    logic             req_valid;
    logic [2:0]       ld_type;
    logic [1:0]       addr_lo;
    logic             stall;
    logic             flush;
    logic             mem_en;
    logic [3:0]       ls_sel;
    logic [WIDTH-1:0] rdata;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             addr_err;

    modport slave (
        input  req_valid, ld_type, addr_lo, stall, flush, rdata,
        output mem_en, ls_sel, rd_valid, rd_data, addr_err
    );

    modport master (
        output req_valid, ld_type, addr_lo, stall, flush, rdata,
        input  mem_en, ls_sel, rd_valid, rd_data, addr_err
    );
endinterface

// File: rtl/load_align_extract.sv
// Lane mux: picks the addressed byte/halfword of a RAM word and
// sign- or zero-extends it according to the load type.
module load_extract
    import load_align_pkg::*;
(
    input  logic [2:0]  ty_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = 8'(word_i >> {off_i, 3'b000});
        half_w = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = '0;
        case (ty_i)
            LD_LB:   data_o = {{24{byte_w[7]}}, byte_w};
            LD_LBU:  data_o = {24'd0, byte_w};
            LD_LH:   data_o = {{16{half_w[15]}}, half_w};
            LD_LHU:  data_o = {16'd0, half_w};
            LD_LW:   data_o = word_i;
            default: data_o = '0;
        endcase
    end
endmodule

// File: rtl/load_align.sv
// MEM/WB load aligner: tracks a load across the one-cycle RAM
// latency and registers the extended result with valid/error flags.
module load_align
    import load_align_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    load_align_if.slave  bus
);
    logic [3:0]       sel;
    logic             aligned;
    logic             adv;
    logic [31:0]      ext;

    s1_t              s1_q, s1_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign sel     = lane_sel(bus.ld_type, bus.addr_lo);
    assign aligned = |sel;
    // Flush forces an update even while stalled so valids drop.
    assign adv     = ~bus.stall | bus.flush;

    assign bus.ls_sel = sel;
    assign bus.mem_en = bus.req_valid & ~bus.stall
                      & ~bus.flush & aligned;

    load_extract u_ext (
        .ty_i   (s1_q.ty),
        .off_i  (s1_q.off),
        .word_i (bus.rdata),
        .data_o (ext)
    );

    always_comb begin
        s1_d       = s1_q;
        rd_valid_d = rd_valid_q;
        err_d      = err_q;
        data_d     = data_q;
        if (adv) begin
            s1_d.valid = bus.req_valid & ~bus.flush;
            s1_d.ty    = bus.ld_type;
            s1_d.off   = bus.addr_lo;
            s1_d.mis   = ~aligned;
            rd_valid_d = s1_q.valid & ~bus.flush;
            err_d      = s1_q.valid & s1_q.mis & ~bus.flush;
            data_d     = s1_q.mis ? '0 : ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q       <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            s1_q       <= s1_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.addr_err = err_q;
    assign bus.rd_data  = data_q;
endmodule

// File: tb/tb_load_align.sv
// Self-checking bench for load_align: transaction-level reference
// model, per-cycle compare process, directed and random loads.
module tb_load_align;
    import load_align_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_align_if #(.WIDTH(32)) bus_if ();

    load_align #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Model: request slot and result slot as transactions.
    bit          m1_v, m1_e;
    logic [31:0] m1_x;
    bit          mo_v, mo_e;
    logic [31:0] mo_x;
    logic [31:0] ram_q;
    logic        l_mem_en;
    logic [3:0]  l_sel;

    function automatic bit legal(input logic [2:0] t,
                                 input logic [1:0] o);
        if (t <= 3'd1) return 1'b1;
        if (t == 3'd2 || t == 3'd3) return (o % 2) == 0;
        if (t == 3'd4) return o == 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] msel(input logic [2:0] t,
                                        input logic [1:0] o);
        if (!legal(t, o)) return 4'd0;
        if (t <= 3'd1) return 4'(1 << o);
        if (t <= 3'd3) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] mexp(input logic [2:0] t,
                                         input logic [1:0] o,
                                         input logic [31:0] w);
        int unsigned v;
        v = 0;
        if (t <= 3'd1) begin
            v = (w >> (8 * o)) & 255;
            if (t == 3'd0 && v >= 128) v = v - 256;
        end else if (t <= 3'd3) begin
            v = (w >> (16 * (o / 2))) & 65535;
            if (t == 3'd2 && v >= 32768) v = v - 65536;
        end else if (t == 3'd4) begin
            v = w;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd_valid", 32'(bus_if.rd_valid), 32'(mo_v));
            chk("addr_err", 32'(bus_if.addr_err), 32'(mo_e));
            if (mo_v) chk("rd_data", bus_if.rd_data, mo_x);
            chk("mem_en", 32'(bus_if.mem_en),
                32'(bus_if.req_valid & ~bus_if.stall & ~bus_if.flush
                    & legal(bus_if.ld_type, bus_if.addr_lo)));
            chk("ls_sel", 32'(bus_if.ls_sel),
                32'(msel(bus_if.ld_type, bus_if.addr_lo)));
        end
    end

    task automatic cyc(input bit rq, input logic [2:0] ty,
                       input logic [1:0] of, input bit st,
                       input bit fl, input bit rn,
                       input logic [31:0] w);
        bit          acc, ok;
        bit          n1_v, n1_e, no_v, no_e;
        logic [31:0] n1_x, no_x, nram;
        bus_if.req_valid = rq;
        bus_if.ld_type   = ty;
        bus_if.addr_lo   = of;
        bus_if.stall     = st;
        bus_if.flush     = fl;
        rst_n            = rn;
        #1;
        l_mem_en = bus_if.mem_en;
        l_sel    = bus_if.ls_sel;
        ok   = legal(ty, of);
        acc  = rq & !st & !fl;
        n1_v = m1_v; n1_e = m1_e; n1_x = m1_x;
        no_v = mo_v; no_e = mo_e; no_x = mo_x;
        nram = ram_q;
        if (acc && ok) nram = w;
        if (!st || fl) begin
            no_v = m1_v & !fl;
            no_e = m1_v & m1_e & !fl;
            no_x = m1_x;
            n1_v = acc;
            n1_e = !ok;
            n1_x = ok ? mexp(ty, of, w) : 32'd0;
        end
        if (!rn) begin
            n1_v = 0; n1_e = 0; n1_x = 0;
            no_v = 0; no_e = 0; no_x = 0;
        end
        @(posedge clk);
        #1;
        m1_v = n1_v; m1_e = n1_e; m1_x = n1_x;
        mo_v = no_v; mo_e = no_e; mo_x = no_x;
        ram_q = nram;
        bus_if.rdata = ram_q;
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic ld(input logic [2:0] ty, input logic [1:0] of,
                      input logic [31:0] w);
        cyc(1'b1, ty, of, 1'b0, 1'b0, 1'b1, w);
    endtask

    initial begin
        logic [31:0] w;
        m1_v = 0; m1_e = 0; m1_x = 0;
        mo_v = 0; mo_e = 0; mo_x = 0;
        ram_q = 0;
        bus_if.rdata = 0;

        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rst_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("rst_data", bus_if.rd_data, 32'd0);
        chk("rst_err", 32'(bus_if.addr_err), 32'd0);
        chk_on = 1'b1;
        idle();

        w = 32'h80FF_1234;
        ld(LD_LB, 2'd3, w);
        chk("lb3_sel", 32'(l_sel), 32'h8);
        chk("lb3_men", 32'(l_mem_en), 32'd1);
        chk("lb3_n1", 32'(bus_if.rd_valid), 32'd0);
        idle();
        chk("lb3_vld", 32'(bus_if.rd_valid), 32'd1);
        chk("lb3_data", bus_if.rd_data, 32'hFFFF_FF80);

        ld(LD_LBU, 2'd3, w);
        ld(LD_LHU, 2'd2, w);
        chk("lbu3", bus_if.rd_data, 32'h0000_0080);
        ld(LD_LH, 2'd0, w);
        chk("lhu2", bus_if.rd_data, 32'h0000_80FF);
        idle();
        chk("lh0", bus_if.rd_data, 32'h0000_1234);

        ld(LD_LW, 2'd0, 32'hDEAD_BEEF);
        ld(LD_LB, 2'd1, 32'h0000_A500);
        chk("b2b_lw", bus_if.rd_data, 32'hDEAD_BEEF);
        idle();
        chk("b2b_lb", bus_if.rd_data, 32'hFFFF_FFA5);

        ld(LD_LW, 2'd1, 32'h1111_1111);
        chk("lwmis_men", 32'(l_mem_en), 32'd0);
        chk("lwmis_sel", 32'(l_sel), 32'd0);
        idle();
        chk("lwmis_vld", 32'(bus_if.rd_valid), 32'd1);
        chk("lwmis_err", 32'(bus_if.addr_err), 32'd1);
        chk("lwmis_data", bus_if.rd_data, 32'd0);
        ld(LD_LH, 2'd3, 32'h2222_2222);
        idle();
        chk("lhmis_err", 32'(bus_if.addr_err), 32'd1);
        chk("lhmis_data", bus_if.rd_data, 32'd0);
        idle();

        ld(LD_LW, 2'd0, 32'h1234_5678);
        cyc(1'b1, LD_LB, 2'd0, 1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA);
        chk("stl_v1", 32'(bus_if.rd_valid), 32'd0);
        cyc(1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0);
        cyc(1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0);
        chk("stl_v3", 32'(bus_if.rd_valid), 32'd0);
        idle();
        chk("stl_vld", 32'(bus_if.rd_valid), 32'd1);
        chk("stl_data", bus_if.rd_data, 32'h1234_5678);
        idle();
        chk("stl_dup", 32'(bus_if.rd_valid), 32'd0);

        ld(LD_LW, 2'd0, 32'h5555_5555);
        cyc(1'b1, LD_LW, 2'd0, 1'b0, 1'b1, 1'b1, 32'h6666_6666);
        chk("fl_men", 32'(l_mem_en), 32'd0);
        idle();
        chk("fl_vld", 32'(bus_if.rd_valid), 32'd0);
        idle();
        chk("fl_drop", 32'(bus_if.rd_valid), 32'd0);

        ld(LD_LW, 2'd0, 32'h7777_7777);
        cyc(1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 32'd0);
        idle();
        chk("flst_vld", 32'(bus_if.rd_valid), 32'd0);

        ld(LD_LW, 2'd0, 32'h9999_9999);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("mrst_vld", 32'(bus_if.rd_valid), 32'd0);
        chk("mrst_data", bus_if.rd_data, 32'd0);
        idle();
        chk("mrst_none", 32'(bus_if.rd_valid), 32'd0);

        repeat (3000) begin
            logic [2:0] t;
            t = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4))
                                           : 3'($urandom_range(5, 7));
            cyc(1'($urandom_range(0, 9) < 7), t,
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) < 2),
                1'($urandom_range(0, 99) < 8),
                1'($urandom_range(0, 99) >= 2),
                $urandom);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
